gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf: RTL and testbench
=====================================================

Name: gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf

Overview:
- Glitch-free programmable clock divider; the source side of the clock tree that feeds the clkbuf cells.
- Divides CLK by a run-time ratio and produces a registered 50%-duty clock Z.
- Ratio changes and enable/disable take effect only at period boundaries, so Z never carries a runt pulse.
- Sits ahead of clkbuf_* drivers in derived-clock generation; functional model only, no timing.

Parameters:
- DIV_W, 8, width of the ratio field DIV.
- DIV_RST, 0, ratio value loaded at reset.

Ports:
- CLK  input  1  source clock; all state updates on its rising edge.
- RST  input  1  asynchronous active-high reset.
- EN  input  1  run request for Z.
- DIV  input  DIV_W  requested ratio field; sampled only on an accepted LOAD.
- LOAD  input  1  ratio update request.
- BUSY  output  1  high while an accepted ratio is pending; LOAD is ignored while BUSY=1.
- DONE  output  1  one-cycle pulse when the pending ratio is applied.
- TICK  output  1  one-cycle pulse coincident with every Z rising transition.
- Z  output  1  divided clock, driven straight from a flop.
- VDD  inout  1  supply; no functional effect.
- VSS  inout  1  ground; no functional effect.

Interface decisions:
- One clock, CLK.
- Reset RST is asynchronous and active-high.

Behaviour:
- Reset values: Z=0, BUSY=0, DONE=0, TICK=0, state=IDLE, cur_div=DIV_RST, cnt=0.
- Phase lengths (default build): H = L = cur_div+1 CLK cycles; period = 2*(cur_div+1); DIV=0 gives /2.
- States:
  - IDLE (Z=0).
  - HIGH (Z=1).
  - LOW (Z=0).
- All outputs are registered.
- IDLE -> HIGH:
  - EN=1 sampled at edge t gives Z=1 and TICK=1 after edge t+1.
  - Pending ratio is applied on this transition; cnt=H-1.
- HIGH -> LOW: when cnt==0; Z=0, cnt=L-1.
- LOW at cnt==0:
  - EN=1: go to HIGH (apply pending ratio, TICK=1, cnt=H-1).
  - EN=0: go to IDLE.
- EN deasserted mid-HIGH or mid-LOW: current high and low phases complete at full length, then IDLE. Z never truncates.
- EN pulsed for a single cycle from IDLE produces exactly one full period.
- LOAD handshake:
  - Accepted when LOAD=1 and BUSY=0; DIV is captured into pend_div and BUSY=1 on the next cycle.
  - In IDLE with EN=0, the pending ratio is applied on the following cycle with a DONE pulse.
  - Otherwise it is applied at the next entry to HIGH.
  - DONE=1 and BUSY=0 occur in the same cycle that Z rises with the new ratio.
- LOAD accepted in the same cycle as a HIGH entry: not applied at that boundary; applied at the next one.
- LOAD while BUSY=1: ignored; pend_div is unchanged.
- Counter is DIV_W wide. cnt reload values never exceed 2^DIV_W-1, so there is no wrap.
- RST asserted mid-operation: immediate return to reset values; any pending ratio is discarded.

Optional Feature:
- Macro: GF180MCU_CLKDIV_ODD_EN.
- Defined:
  - DIV means period-1; period P = DIV+1, with DIV<1 forced to 1.
  - H = ceil(P/2), L = floor(P/2).
  - Odd ratios are allowed; duty is (P+1)/2P for odd P.
- Undefined: even-only mapping as above.
- Handshake and state machine are identical in both builds.

Decomposition:
- Shared package gf180mcu_clkdiv_pkg holds:
  - state enum {IDLE, HIGH, LOW};
  - DIV_W default;
  - function phase_len(div, is_high) returning H/L under either macro setting.
- One natural sub-module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf_ratio, owning the LOAD/BUSY/DONE handshake and pend_div register.

Test Plan:
- Reset/enable: RST pulse, DIV_RST=0, EN=1 -> Z toggles every cycle (/2); first Z rise one cycle after EN sampled; TICK on every rise.
- Ratio change: running at DIV=2 (period 6), LOAD with DIV=4 mid-HIGH -> BUSY=1; current period stays 3H/3L; next period 5H/5L; DONE coincides with that rise.
- Back-to-back LOAD: second LOAD (DIV=7) while BUSY -> ignored; ratio becomes the first value only; BUSY drops with DONE.
- Clean stop: EN=0 one cycle into a 4-cycle HIGH (DIV=3) -> Z holds 4H+4L then IDLE with Z=0; no pulse shorter than 4 cycles.
- Async reset mid-LOW with a pending load -> Z=0, BUSY=0, DONE=0 immediately, without a CLK edge; restart uses DIV_RST.
- With GF180MCU_CLKDIV_ODD_EN: DIV=4 (P=5) -> Z pattern 3H/2L repeating; DIV=0 -> forced P=2 (1H/1L).

Source files
------------

// File: rtl/gf180mcu_clkdiv_pkg.sv
// gf180mcu_clkdiv_pkg: shared state type, default width and phase-length math for the clock divider
// Build option GF180MCU_CLKDIV_ODD_EN: DIV is period-1 (odd periods allowed, DIV<1 forced to 1);
// otherwise both phases last DIV+1 cycles (period 2*(DIV+1)).
package gf180mcu_clkdiv_pkg;
  localparam int DIV_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  function automatic int unsigned phase_len(input int unsigned div, input logic is_high);
`ifdef GF180MCU_CLKDIV_ODD_EN
    int unsigned p;
    p = (div < 32'd1 ? 32'd1 : div) + 32'd1;
    return is_high ? (p + 32'd1) / 32'd2 : p / 32'd2;
`else
    return is_high ? div + 32'd1 : div + 32'd1;
`endif
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf_ratio.sv
// gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf_ratio: LOAD/BUSY/DONE handshake and pending-ratio register
// Ports: clk_i/rst_i clock and async reset; load_i/div_i ratio request; apply_i consume pending ratio;
// busy_o pending flag; done_o one-cycle apply pulse; pend_div_o captured ratio.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf_ratio #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             apply_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DIV_W-1:0] pend_div_o
);
  logic busy_q, busy_d, done_q, done_d, accept;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  always_comb begin
    accept = load_i & ~busy_q;
    busy_d = accept | (busy_q & ~apply_i);
    done_d = apply_i;
    pend_div_d = accept ? div_i : pend_div_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pend_div_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      pend_div_q <= pend_div_d;
    end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pend_div_o = pend_div_q;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf.sv
// gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf: glitch-free programmable clock divider with registered Z
// Ports: CLK source clock; RST async active-high reset; EN run request; DIV/LOAD ratio update;
// BUSY ratio pending; DONE ratio applied pulse; TICK pulse with each Z rise; Z divided clock;
// VDD/VSS supplies (no function). Build option GF180MCU_CLKDIV_ODD_EN enables odd ratios.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf
  import gf180mcu_clkdiv_pkg::*;
#(
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic             TICK,
  output logic             Z,
  inout  wire              VDD,
  inout  wire              VSS
);
  state_e state_q;
  logic [DIV_W-1:0] cnt_q, cur_div_q, pend_div, div_nx, cnt_h, cnt_l;
  logic en_q, z_q, tick_q, busy, apply, enter_high, cnt_zero;
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;
  gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf_ratio #(.DIV_W(DIV_W)) u_ratio (
    .clk_i(CLK),
    .rst_i(RST),
    .load_i(LOAD),
    .div_i(DIV),
    .apply_i(apply),
    .busy_o(busy),
    .done_o(DONE),
    .pend_div_o(pend_div)
  );
  // Ratio changes only at a HIGH entry or while parked in IDLE, so every phase runs at one ratio.
  always_comb begin
    cnt_zero = (cnt_q == '0);
    enter_high = en_q & ((state_q == IDLE) | ((state_q == LOW) & cnt_zero));
    apply = busy & ((state_q == IDLE) | enter_high);
    div_nx = apply ? pend_div : cur_div_q;
    cnt_h = DIV_W'(phase_len(32'(div_nx), 1'b1) - 32'd1);
    cnt_l = DIV_W'(phase_len(32'(cur_div_q), 1'b0) - 32'd1);
  end
  // EN is registered first, so a run request shows on Z one cycle after it is sampled.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_div_q <= DIV_RST;
      z_q <= 1'b0;
      tick_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      en_q <= EN;
      tick_q <= enter_high;
      cur_div_q <= div_nx;
      if (enter_high) begin
        state_q <= HIGH;
        z_q <= 1'b1;
        cnt_q <= cnt_h;
      end else if ((state_q == HIGH) && cnt_zero) begin
        state_q <= LOW;
        z_q <= 1'b0;
        cnt_q <= cnt_l;
      end else if ((state_q == LOW) && cnt_zero) begin
        state_q <= IDLE;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  assign BUSY = busy;
  assign TICK = tick_q;
  assign Z = z_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf: self-checking bench with vector table, directed sequences and waveform-queue model
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [7:0] div = 8'd0;
  wire busy, done, tick, z;
  wire vdd = 1'b1;
  wire vss = 1'b0;
  int n_chk = 0, n_fail = 0;
  bit chk = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_gf dut (
    .CLK(clk), .RST(rst), .EN(en), .DIV(div), .LOAD(load),
    .BUSY(busy), .DONE(done), .TICK(tick), .Z(z), .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  function automatic int ph(input int d, input bit hi);
`ifdef GF180MCU_CLKDIV_ODD_EN
    int p;
    p = (d < 1 ? 1 : d) + 1;
    return hi ? (p + 1) / 2 : p / 2;
`else
    return hi ? d + 1 : d + 1;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a started period is laid out as a queue of future (tick,z) samples.
  bit [1:0] q[$];
  bit [1:0] m_e;
  bit m_en_prev, m_running, m_busy, m_done, m_tick, m_z, m_apply, m_start;
  bit [7:0] m_cur, m_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_en_prev = 0; m_running = 0; m_busy = 0; m_done = 0;
      m_tick = 0; m_z = 0; m_cur = 0; m_pend = 0;
    end else begin
      m_apply = 0;
      m_start = 0;
      if (q.size() == 0) begin
        if (m_en_prev) begin
          m_start = 1;
          m_apply = m_busy;
        end else if (m_running) m_running = 0;
        else m_apply = m_busy;
      end
      if (m_apply) m_cur = m_pend;
      if (m_start) begin
        m_running = 1;
        for (int i = 0; i < ph(int'(m_cur), 1'b1); i++) q.push_back(i == 0 ? 2'b11 : 2'b01);
        for (int i = 0; i < ph(int'(m_cur), 1'b0); i++) q.push_back(2'b00);
      end
      if (q.size() > 0) m_e = q.pop_front();
      else m_e = 2'b00;
      {m_tick, m_z} = m_e;
      m_done = m_apply;
      if (load && !m_busy) begin
        m_pend = div;
        m_busy = 1;
      end else if (m_apply) m_busy = 0;
      m_en_prev = en;
    end
  end

  always @(negedge clk)
    if (chk) begin
      check("model_z", z, m_z);
      check("model_tick", tick, m_tick);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; div = 8'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_level(input logic v);
    int n = 0;
    while (z !== v && n < 600) begin
      step();
      n++;
    end
    check("wait_z_level", z, v);
  endtask

  task automatic run_len(output int len, input int max);
    logic v;
    v = z;
    len = 0;
    while (z === v && len < max) begin
      step();
      len++;
    end
  endtask

  task automatic load_idle(input logic [7:0] d);
    load = 1'b1; div = d;
    step();
    load = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic en, ld;
    logic [7:0] dv;
    logic ez, et, eb, ed;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int len, h;
    tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    chk = 1'b1;
    check("reset_z", z, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tick", tick, 0);
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; load = tbl[i].ld; div = tbl[i].dv;
      step();
      check($sformatf("vec%0d_z", i), z, tbl[i].ez);
      check($sformatf("vec%0d_tick", i), tick, tbl[i].et);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("vec%0d_done", i), done, tbl[i].ed);
    end
    // Ratio change mid-HIGH, second LOAD while busy is ignored.
    do_reset();
    load_idle(8'd2);
    en = 1'b1;
    wait_level(1'b1);
    load = 1'b1; div = 8'd4;
    step();
    div = 8'd7;
    step();
    load = 1'b0;
    check("chg_busy_pending", busy, 1);
    wait_level(1'b0);
    run_len(len, 600);
    check("chg_old_low_len", len, ph(2, 1'b0));
    check("chg_done_at_rise", done, 1);
    check("chg_busy_clear", busy, 0);
    check("chg_tick_at_rise", tick, 1);
    run_len(len, 600);
    check("chg_new_high_len", len, ph(4, 1'b1));
    run_len(len, 600);
    check("chg_new_low_len", len, ph(4, 1'b0));
    run_len(len, 600);
    check("chg_ignored_high_len", len, ph(4, 1'b1));
    // Clean stop one cycle into HIGH: full phases, then parked low.
    do_reset();
    load_idle(8'd3);
    en = 1'b1;
    wait_level(1'b1);
    step();
    en = 1'b0;
    run_len(h, 600);
    check("stop_high_len", h + 1, ph(3, 1'b1));
    run_len(len, 3 * ph(3, 1'b0) + 12);
    check("stop_parked_low", len, 3 * ph(3, 1'b0) + 12);
    // Async reset mid-LOW with a pending ratio; restart runs at DIV_RST.
    do_reset();
    load_idle(8'd3);
    en = 1'b1;
    wait_level(1'b1);
    wait_level(1'b0);
    load = 1'b1; div = 8'd5;
    step();
    load = 1'b0;
    check("ar_busy_before", busy, 1);
    check("ar_z_low_before", z, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_z", z, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_tick", tick, 0);
    step();
    step();
    rst = 1'b0;
    wait_level(1'b1);
    run_len(len, 600);
    check("ar_restart_high_len", len, ph(0, 1'b1));
    run_len(len, 600);
    check("ar_restart_low_len", len, ph(0, 1'b0));
    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) en = ~en;
      load = ($urandom_range(7) == 0);
      div = 8'($urandom_range(9));
      step();
    end
    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
